// File: rtl/mio_responder.sv
// Target end of the CPU memory request bus: decodes word accesses to RAM or the
// IO register window, runs them with fixed wait states and returns data plus ack.
module mio_responder #(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned IO_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mio_ready,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    output logic [3:0]  io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        io_rd,
    input  logic [31:0] io_rdata,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
    localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

    state_t      state;
    logic [3:0]  cnt;
    logic        first;
    logic        is_write;
    logic        is_io;
    logic        err_pend;
    logic [31:0] data_q;

    logic hit_ram;
    logic hit_io;
    logic bad_req;

    assign hit_ram = (addr[31:12] == 20'd0);
    assign hit_io  = (addr[31:6] == 26'h3800000);
    assign bad_req = (!hit_ram && !hit_io) || (addr[1:0] != 2'b00) || (mem_r && mem_w);

    // Handshake and strobes come from registered state only, never from the request inputs.
    assign mio_ready = (state == IDLE);
    assign ack       = (state == RESP);
    assign err       = (state == RESP) && err_pend;
    assign ram_we    = (state == ACCESS) && first && is_write && !is_io;
    assign io_we     = (state == ACCESS) && first && is_write && is_io;
    assign io_rd     = (state == ACCESS) && first && !is_write && is_io;
    assign ram_din   = data_q;
    assign io_wdata  = data_q;
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            first    <= 1'b0;
            is_write <= 1'b0;
            is_io    <= 1'b0;
            err_pend <= 1'b0;
            data_q   <= 32'd0;
            ram_addr <= 10'd0;
            io_addr  <= 4'd0;
            rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_r || mem_w) begin
                        if (bad_req) begin
                            err_pend <= 1'b1;
                            state    <= RESP;
                        end else begin
                            err_pend <= 1'b0;
                            is_write <= mem_w;
                            is_io    <= hit_io;
                            ram_addr <= addr[11:2];
                            io_addr  <= addr[5:2];
                            data_q   <= wdata;
                            cnt      <= hit_io ? IO_CNT : RAM_CNT;
                            first    <= 1'b1;
                            state    <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    first <= 1'b0;
                    cnt   <= cnt - 4'd1;
                    // cnt==1 marks the last wait cycle; read data is sampled on this edge.
                    if (cnt <= 4'd1) begin
                        if (!is_write) begin
                            rdata <= is_io ? io_rdata : ram_dout;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    err_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: directed and random transactions checked
// against a transaction-level reference of the address map and memory contents.
module tb_mio_responder;
    localparam int RW = 2;
    localparam int IW = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r, mem_w;
    logic [31:0] addr, wdata;
    logic        mio_ready, ack, err;
    logic [31:0] rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_we;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic        io_we, io_rd;
    logic [1:0]  state_out;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] io_mem  [0:15];
    logic [31:0] ref_ram [0:1023];
    logic [31:0] ref_io  [0:15];
    logic [31:0] exp_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = 0;

    mio_responder #(.RAM_WAIT(RW), .IO_WAIT(IW)) dut (
        .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .mio_ready(mio_ready), .ack(ack), .err(err), .rdata(rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_rd(io_rd),
        .io_rdata(io_rdata), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Simple device models driven only by the DUT's strobes.
    assign ram_dout = ram_mem[ram_addr];
    assign io_rdata = io_mem[io_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        if (io_we)  io_mem[io_addr]   <= io_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 = error request, 1 = RAM, 2 = IO
    function automatic int classify(input logic r, input logic w, input logic [31:0] a);
        if (r && w) return 0;
        if (a % 4 != 0) return 0;
        if (a < 32'h0000_1000) return 1;
        if (a >= 32'hE000_0000 && a <= 32'hE000_003F) return 2;
        return 0;
    endfunction

    // Entered and left at a negedge in an IDLE cycle.
    task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit drop_late);
        int  kind, len, ridx;
        bit  last;
        kind = classify(r, w, a);
        len  = (kind == 0) ? 1 : ((kind == 1) ? RW : IW) + 1;
        chk("idle_ready", mio_ready, 1'b1);
        mem_r = r; mem_w = w; addr = a; wdata = d;
        if (kind == 1) begin
            ridx = int'(a / 4);
            if (w) ref_ram[ridx] = d; else exp_rdata = ref_ram[ridx];
        end else if (kind == 2) begin
            ridx = int'((a - 32'hE000_0000) / 4);
            if (w) ref_io[ridx] = d; else exp_rdata = ref_io[ridx];
        end
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            last = (c == len);
            chk("ack", ack, last);
            chk("err", err, last && kind == 0);
            chk("ready_busy", mio_ready, 1'b0);
            chk("state", {30'd0, state_out}, last ? 32'd2 : 32'd1);
            chk("ram_we", ram_we, c == 1 && kind == 1 && w);
            chk("io_we", io_we, c == 1 && kind == 2 && w);
            chk("io_rd", io_rd, c == 1 && kind == 2 && !w);
            if (kind == 1 && !last) begin
                chk("ram_addr", {22'd0, ram_addr}, a / 4);
                if (w) chk("ram_din", ram_din, d);
            end
            if (kind == 2 && !last) begin
                chk("io_addr", {28'd0, io_addr}, (a - 32'hE000_0000) / 4);
                if (w) chk("io_wdata", io_wdata, d);
            end
            if (last) begin
                chk("rdata", rdata, exp_rdata);
                ack_cyc = cyc;
                if (!drop_late) begin mem_r = 1'b0; mem_w = 1'b0; end
            end
        end
        if (drop_late) begin
            @(posedge clk); #1;
            mem_r = 1'b0; mem_w = 1'b0;
        end
        @(negedge clk);
        chk("post_state", {30'd0, state_out}, 32'd0);
        chk("post_ack", ack, 1'b0);
        if (drop_late) begin
            @(negedge clk);
            chk("no_double_accept", {30'd0, state_out}, 32'd0);
        end
    endtask

    initial begin
        int a1, sel;
        logic [31:0] a, d;
        logic r, w;
        for (int i = 0; i < 1024; i++) begin ram_mem[i] = 32'd0; ref_ram[i] = 32'd0; end
        for (int i = 0; i < 16; i++) begin io_mem[i] = 32'd0; ref_io[i] = 32'd0; end
        exp_rdata = 32'd0;
        reset = 1'b0; mem_r = 1'b1; mem_w = 1'b0; addr = 32'd0; wdata = 32'd0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_ack", ack, 1'b0);
            chk("rst_strobes", {29'd0, ram_we, io_we, io_rd}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_state", {30'd0, state_out}, 32'd0);
        end
        reset = 1'b1;
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);

        io_mem[2] = 32'h1234_5678; ref_io[2] = 32'h1234_5678;
        do_txn(1'b1, 1'b0, 32'hE000_0008, 32'h0, 1'b0);
        do_txn(1'b0, 1'b1, 32'hE000_000C, 32'hCAFE_0001, 1'b0);
        do_txn(1'b1, 1'b0, 32'hE000_000C, 32'h0, 1'b0);

        do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_0002, 32'h0, 1'b0);
        do_txn(1'b1, 1'b1, 32'h0000_0000, 32'h5555_5555, 1'b0);

        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("idle_ready", mio_ready, 1'b1);
        mem_r = 1'b1; addr = 32'h0000_0010;
        @(negedge clk);
        mem_r = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_state", {30'd0, state_out}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_ack", ack, 1'b0);
        reset = 1'b1;
        exp_rdata = 32'd0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_ack", ack, 1'b0);
        end

        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        a1 = ack_cyc;
        do_txn(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0);
        chk("ack_spacing_ram", ack_cyc - a1, RW + 2);
        a1 = ack_cyc;
        do_txn(1'b1, 1'b0, 32'hE000_0008, 32'h0, 1'b0);
        chk("ack_spacing_io", ack_cyc - a1, IW + 2);
        do_txn(1'b0, 1'b1, 32'h0000_0024, 32'h7777_0000, 1'b1);
        do_txn(1'b1, 1'b0, 32'h0000_0024, 32'h0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            r = $urandom_range(0, 1);
            w = !r;
            d = $urandom;
            case (sel)
                0, 1, 2: a = 32'($urandom_range(0, 15)) * 4;
                3:       a = 32'hE000_0000 + 32'($urandom_range(0, 15)) * 4;
                4:       a = 32'h0000_1000 + 32'($urandom_range(0, 1000)) * 4;
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                    end else begin
                        a = 32'($urandom_range(0, 15)) * 4; r = 1'b1; w = 1'b1;
                    end
                end
            endcase
            do_txn(r, w, a, d, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
